mig_stream_eval: RTL and testbench
==================================

Name: mig_stream_eval

Overview:
- Evaluates a majority-inverter graph (MIG) supplied as a serialized stream of 3-input majority node records against one latched primary-input vector.
- Consumes the node list that the netlist writer emits in topological order: it reads the list rather than writing it.
- Sits between the MIG netlist loader (record source) and the regression checker (result sink).
- Used in hardware to compare generated netlists against golden values.

Parameters:
- NUM_PI, 4, number of primary inputs (pi vector width).
- MAX_NODES, 128, capacity of the node value store, gate nodes only.
- IDX_W, 8, node index width; must satisfy 2^IDX_W >= 1+NUM_PI+MAX_NODES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches pi and begins a new evaluation; ignored unless state=IDLE.
- pi  in  NUM_PI  primary input vector, sampled on start.
- rec_valid  in  1  node record valid.
- rec_ready  out  1  block accepts the record this cycle.
- rec_fanin  in  3*(IDX_W+1)  three fanins, each {compl, idx}; fanin0 in the LSBs.
- rec_last  in  1  this record is the primary output node.
- res_valid  out  1  result available.
- res_ready  in  1  sink accepts the result.
- po  out  1  value of the last node.
- node_cnt  out  IDX_W  gate nodes evaluated.
- err  out  1  evaluation aborted; see Behaviour.

Behaviour:
- Index space:
  - 0 = constant 0 (compl gives 1).
  - 1..NUM_PI = pi[idx-1].
  - NUM_PI+1 upward = gate nodes, numbered in acceptance order.
- Reset (async, rst_n=0):
  - state=IDLE; rec_ready=0, res_valid=0, po=0, node_cnt=0, err=0.
  - Value store is not cleared.
- States: IDLE, EVAL, DONE.
- IDLE:
  - rec_ready=0.
  - start=1 -> latch pi, clear node_cnt, po and err, go to EVAL.
- EVAL:
  - rec_ready=1. A record transfers when rec_valid&rec_ready.
  - Operand o_k = value(idx_k) XOR compl_k.
  - Node value = (o0&o1)|(o0&o2)|(o1&o2).
  - The value is written at index NUM_PI+1+node_cnt on the accepting edge; node_cnt increments.
  - Operands are read combinationally from a flop array.
  - A record may reference the node accepted on the previous cycle (write-before-read bypass not needed; flop write completes first).
  - rec_last transfer -> po=node value, go to DONE.
- DONE:
  - res_valid=1, rec_ready=0.
  - res_valid&res_ready -> IDLE.
  - po, node_cnt and err stay stable until the handshake completes.
- Latency: last record accepted on edge N -> res_valid=1 from cycle N+1.
- Error: forward reference (any idx >= NUM_PI+1+node_cnt) on an accepted record:
  - err=1, po=0, go to DONE immediately.
  - The offending record is consumed and not stored.
- Error: overflow (record accepted with node_cnt==MAX_NODES):
  - Same handling: err=1, go to DONE.
  - Exactly MAX_NODES records are legal.
- rec_last together with an error: error wins, po=0.
- start outside IDLE is ignored. Records while not in EVAL are not accepted.
- Reset mid-evaluation: abort to IDLE within the same cycle; results are discarded.
- Counters saturate-free by construction; node_cnt never exceeds MAX_NODES.

Optional Feature:
- Macro MIG_TRACE_EN.
- Defined:
  - Adds outputs trace_valid (1), trace_idx (IDX_W), trace_val (1).
  - These are registered, one cycle after each successfully stored node: index and value.
  - No back-pressure on trace. Reset value 0.
- Undefined: ports absent, no extra flops. Core behaviour is identical either way.

Decomposition:
- Package mig_pkg:
  - fanin_t struct {compl, idx}.
  - state enum.
  - Constant CONST0_IDX=0.
  - Function maj3(a,b,c).
- One sub-module mig_node_store: flop array with 3 async read ports and 1 write port, where index 0 and PI indices are decoded outside it.

Test Plan:
- pi=4'b0011, records maj(pi0,pi1,~c0) last -> po=1, node_cnt=1; repeat with pi=4'b0000 -> po=0.
- pi=4'b1100:
  - n5=maj(pi2,pi3,c0)=1.
  - n6=maj(pi3,~c0,c0)=1.
  - n7=maj(n5,n6,c0) last -> po=1, res_valid one cycle after the last accept.
- Record with idx=7 while node_cnt=0 (NUM_PI=4) -> err=1, po=0, DONE, no further rec_ready.
- Stream MAX_NODES records, last on record 128 -> po correct, err=0; a 129th record without last -> err=1.
- Hold res_ready=0 for 10 cycles -> res_valid, po and node_cnt stable; start pulses ignored; rec_valid not accepted.
- Assert rst_n=0 mid-stream after 3 records -> all outputs 0 immediately; next start evaluates a fresh stream correctly.

Source files
------------

// File: rtl/mig_pkg.sv
// Shared types and helpers for the MIG stream evaluator.
// The record layout here matches the netlist loader's {compl, idx} fanin encoding.
package mig_pkg;

  localparam int MIG_IDX_W = 8;
  localparam logic [MIG_IDX_W-1:0] CONST0_IDX = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 compl;
    logic [MIG_IDX_W-1:0] idx;
  } fanin_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mig_node_store.sv
// Gate-node value store: one write port, three combinational read ports.
// Constant and primary-input indices are resolved by the caller, so only gate slots live here.
module mig_node_store #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic [AW-1:0] rd_addr [3],
  output logic          rd_data [3]
);

  logic mem [DEPTH];

  // Contents are deliberately not reset; every slot is written before it can be legally read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_data[k] = mem[rd_addr[k]];
    end
  end

endmodule

// File: rtl/mig_stream_eval.sv
// Evaluates a topologically ordered stream of majority-node records against a latched PI vector.
// Define MIG_TRACE_EN to add the registered trace_valid/trace_idx/trace_val node trace outputs.
module mig_stream_eval
  import mig_pkg::*;
#(
  parameter int NUM_PI    = 4,
  parameter int MAX_NODES = 128,
  parameter int IDX_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_PI-1:0]      pi,
  input  logic                   rec_valid,
  output logic                   rec_ready,
  input  logic [3*(IDX_W+1)-1:0] rec_fanin,
  input  logic                   rec_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   po,
  output logic [IDX_W-1:0]       node_cnt,
`ifdef MIG_TRACE_EN
  output logic                   trace_valid,
  output logic [IDX_W-1:0]       trace_idx,
  output logic                   trace_val,
`endif
  output logic                   err
);

  localparam int AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int PW = $clog2(NUM_PI + 1);
  localparam int FW = IDX_W + 1;
  localparam logic [IDX_W:0]   GATE_BASE = (IDX_W + 1)'(NUM_PI + 1);
  localparam logic [IDX_W-1:0] PI_LAST   = IDX_W'(NUM_PI);
  localparam logic [IDX_W-1:0] CNT_MAX   = IDX_W'(MAX_NODES);

  state_t state_q, state_d;

  logic [NUM_PI-1:0] pi_q;
  logic [NUM_PI:0]   pi_ext;
  logic [IDX_W-1:0]  f_idx   [3];
  logic              f_cmp   [3];
  logic [AW-1:0]     rd_addr [3];
  logic              rd_data [3];
  logic              opnd    [3];
  logic [IDX_W:0]    lim;
  logic              fwd_err, ovf_err, rec_err;
  logic              accept, store_en, node_val;

  assign pi_ext = {pi_q, 1'b0};
  assign lim    = GATE_BASE + {1'b0, node_cnt};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      f_idx[k]   = rec_fanin[k*FW +: IDX_W];
      f_cmp[k]   = rec_fanin[k*FW + IDX_W];
      rd_addr[k] = AW'(f_idx[k] - GATE_BASE[IDX_W-1:0]);
    end
  end

  // Operand decode: constant, primary input or stored gate value, then the complement flag.
  always_comb begin
    fwd_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      opnd[k] = f_cmp[k];
      if (f_idx[k] == IDX_W'(CONST0_IDX)) begin
        opnd[k] = f_cmp[k];
      end else if (f_idx[k] <= PI_LAST) begin
        opnd[k] = pi_ext[PW'(f_idx[k])] ^ f_cmp[k];
      end else begin
        opnd[k] = rd_data[k] ^ f_cmp[k];
      end
      if ({1'b0, f_idx[k]} >= lim) fwd_err = 1'b1;
    end
  end

  assign ovf_err  = (node_cnt == CNT_MAX);
  assign rec_err  = fwd_err | ovf_err;
  assign accept   = rec_valid & rec_ready;
  assign store_en = accept & ~rec_err;
  assign node_val = maj3(opnd[0], opnd[1], opnd[2]);

  mig_node_store #(
    .DEPTH (MAX_NODES),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .wr_en   (store_en),
    .wr_addr (AW'(node_cnt)),
    .wr_data (node_val),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rec_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EVAL;
      ST_EVAL: begin
        rec_ready = 1'b1;
        if (rec_valid && (rec_err || rec_last)) state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) pi_q <= pi;
  end

  // An error on the accepted record overrides rec_last and forces po low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_cnt <= '0;
      po       <= 1'b0;
      err      <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      node_cnt <= '0;
      po       <= 1'b0;
      err      <= 1'b0;
    end else if (accept) begin
      if (rec_err) begin
        err <= 1'b1;
        po  <= 1'b0;
      end else begin
        node_cnt <= node_cnt + 1'b1;
        if (rec_last) po <= node_val;
      end
    end
  end

`ifdef MIG_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_idx   <= '0;
      trace_val   <= 1'b0;
    end else begin
      trace_valid <= store_en;
      if (store_en) begin
        trace_idx <= lim[IDX_W-1:0];
        trace_val <= node_val;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mig_stream_eval.sv
// Randomized scoreboard bench for mig_stream_eval against a list-based MIG reference model.
module tb_mig_stream_eval;
  import mig_pkg::*;

  localparam int NUM_PI    = 4;
  localparam int MAX_NODES = 128;
  localparam int IDX_W     = 8;
  localparam int RW        = 3 * (IDX_W + 1);

  typedef struct packed {
    logic   last;
    fanin_t f2;
    fanin_t f1;
    fanin_t f0;
  } rec_t;

  typedef struct packed {
    logic             po;
    logic [IDX_W-1:0] cnt;
    logic             err;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [NUM_PI-1:0] pi = '0;
  logic              rec_valid = 1'b0;
  logic              rec_ready;
  logic [RW-1:0]     rec_fanin = '0;
  logic              rec_last = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic              po;
  logic [IDX_W-1:0]  node_cnt;
  logic              err;

  int   total = 0;
  int   bad   = 0;
  res_t sb[$];
  rec_t recs[$];

  mig_stream_eval #(
    .NUM_PI    (NUM_PI),
    .MAX_NODES (MAX_NODES),
    .IDX_W     (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pi        (pi),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_fanin (rec_fanin),
    .rec_last  (rec_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .po        (po),
    .node_cnt  (node_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fanin_t fi(input logic c, input int idx);
    fanin_t f;
    f.compl = c;
    f.idx   = idx[IDX_W-1:0];
    return f;
  endfunction

  function automatic rec_t mk(input fanin_t a, input fanin_t b, input fanin_t c, input logic last);
    rec_t r;
    r.f0 = a; r.f1 = b; r.f2 = c; r.last = last;
    return r;
  endfunction

  // Reference: value table indexed by node number, majority as "at least two operands true".
  function automatic void model_eval(input logic [NUM_PI-1:0] p, input rec_t r[$],
                                     output logic e_po, output int e_cnt,
                                     output logic e_err, output int n_used);
    bit     v [256];
    int     cnt;
    int     ones;
    bit     badrec;
    bit     val;
    fanin_t fs [3];
    cnt = 0; e_po = 0; e_err = 0; e_cnt = 0; n_used = r.size();
    v[0] = 0;
    for (int i = 1; i <= NUM_PI; i++) v[i] = p[i-1];
    for (int j = 0; j < r.size(); j++) begin
      fs[0] = r[j].f0; fs[1] = r[j].f1; fs[2] = r[j].f2;
      ones = 0;
      badrec = (cnt == MAX_NODES);
      for (int k = 0; k < 3; k++) begin
        if (int'(fs[k].idx) >= 1 + NUM_PI + cnt) badrec = 1;
        else if (v[fs[k].idx] != fs[k].compl) ones++;
      end
      if (badrec) begin
        e_err = 1; e_po = 0; e_cnt = cnt; n_used = j + 1;
        return;
      end
      val = (ones >= 2);
      v[1 + NUM_PI + cnt] = val;
      cnt++;
      if (r[j].last) begin
        e_po = val; e_cnt = cnt; n_used = j + 1;
        return;
      end
    end
    e_cnt = cnt;
  endfunction

  // Random legal stream; optionally one fanin of one record points forward.
  task automatic gen_random(input int len, input bit inject, input bit use_last);
    int bad_at;
    int bad_k;
    fanin_t fs [3];
    recs.delete();
    bad_at = inject ? int'($urandom_range(0, len - 1)) : -1;
    bad_k  = int'($urandom_range(0, 2));
    for (int j = 0; j < len; j++) begin
      for (int k = 0; k < 3; k++) begin
        if (j == bad_at && k == bad_k)
          fs[k] = fi($urandom_range(0, 1), 1 + NUM_PI + j + int'($urandom_range(0, 2)));
        else
          fs[k] = fi($urandom_range(0, 1), int'($urandom_range(0, NUM_PI + j)));
      end
      recs.push_back(mk(fs[0], fs[1], fs[2], use_last && (j == len - 1)));
    end
  endtask

  task automatic send(input rec_t r);
    int w;
    w = 0;
    rec_valid = 1'b1;
    rec_fanin = {r.f2, r.f1, r.f0};
    rec_last  = r.last;
    while (!rec_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rec_ready", 32'(rec_ready), 32'd1);
    if (rec_ready) begin
      @(posedge clk); #1;
    end
    rec_valid = 1'b0;
    rec_last  = 1'b0;
  endtask

  task automatic run_eval(input logic [NUM_PI-1:0] p, input int hold);
    logic e_po, e_err;
    int   e_cnt, n;
    res_t e;
    model_eval(p, recs, e_po, e_cnt, e_err, n);
    e.po = e_po; e.cnt = e_cnt[IDX_W-1:0]; e.err = e_err;
    sb.push_back(e);
    res_ready = (hold == 0);
    pi = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pi = ~p;
    for (int j = 0; j < n; j++) send(recs[j]);
    chk("latency_res_valid", 32'(res_valid), 32'd1);
    chk("done_no_ready", 32'(rec_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      start = h[0]; rec_valid = 1'b1; rec_last = 1'b1;
      rec_fanin = RW'($urandom);
      @(posedge clk); #1;
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_po", 32'(po), 32'(e_po));
      chk("hold_cnt", 32'(node_cnt), 32'(e.cnt));
      chk("hold_err", 32'(err), 32'(e_err));
      chk("hold_no_ready", 32'(rec_ready), 32'd0);
    end
    start = 1'b0; rec_valid = 1'b0; rec_last = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle", 32'(res_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: result po=%0d cnt=%0d err=%0d with nothing expected", po, node_cnt, err);
      end else begin
        e = sb.pop_front();
        chk("sb_po", 32'(po), 32'(e.po));
        chk("sb_cnt", 32'(node_cnt), 32'(e.cnt));
        chk("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    #3 rst_n = 1'b0;
    #2;
    chk("rst_rec_ready", 32'(rec_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_po", 32'(po), 32'd0);
    chk("rst_cnt", 32'(node_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // maj(pi0, pi1, ~c0)
    recs.delete();
    recs.push_back(mk(fi(0, 1), fi(0, 2), fi(1, 0), 1));
    run_eval(4'b0011, 0);
    run_eval(4'b0000, 0);

    // three-node chain, result held for 10 cycles
    recs.delete();
    recs.push_back(mk(fi(0, 3), fi(0, 4), fi(0, 0), 0));
    recs.push_back(mk(fi(0, 4), fi(1, 0), fi(0, 0), 0));
    recs.push_back(mk(fi(0, 5), fi(0, 6), fi(0, 0), 1));
    run_eval(4'b1100, 10);

    // forward reference on the first record
    recs.delete();
    recs.push_back(mk(fi(0, 7), fi(0, 1), fi(0, 2), 0));
    run_eval(4'b1111, 0);

    // exactly MAX_NODES records, then one too many
    gen_random(MAX_NODES, 0, 1);
    run_eval(4'($urandom), 0);
    gen_random(MAX_NODES + 1, 0, 0);
    run_eval(4'($urandom), 0);

    // reset in the middle of a stream
    gen_random(6, 0, 1);
    pi = 4'b1010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 3; j++) send(recs[j]);
    chk("pre_rst_cnt", 32'(node_cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_rec_ready", 32'(rec_ready), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_po", 32'(po), 32'd0);
    chk("midrst_cnt", 32'(node_cnt), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    gen_random(5, 0, 1);
    run_eval(4'b0110, 0);

    for (int t = 0; t < 40; t++) begin
      gen_random(int'($urandom_range(1, 12)), ($urandom_range(0, 3) == 0), 1);
      run_eval(4'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
